// File: rtl/dm_pkg.sv
// Shared definitions for the dual-requester memory arbiter: default widths,
// burst default and FSM state encodings.
package dm_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned BURST_W       = 4;
    localparam int unsigned STAT_W        = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/dm_arb_counter.sv
// Saturating up-counter with synchronous clear; used for the burst length
// and for the optional statistics counters.
module dm_arb_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester single-port memory arbiter with burst-limited ownership and
// a toggling priority pointer for simultaneous requests from IDLE.
// Optional statistics counters are built when DM_ARBITER_STATS_EN is defined.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] write_address,
    output logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] MemData_out
`ifdef DM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt_0,
    output logic [STAT_W-1:0] grant_cnt_1,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               ptr;
    logic               ptr_next;
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_last;
    logic               burst_clr;
    logic               gnt_any;

    assign gnt_0      = (state == ST_OWN0) && req_0;
    assign gnt_1      = (state == ST_OWN1) && req_1;
    assign gnt_any    = gnt_0 || gnt_1;
    assign burst_last = (burst_cnt == BURST_LAST);

    // State and priority pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state: idle arbitration, release handoff and burst-limit handoff.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_0 && req_1) begin
                    state_next = ptr ? ST_OWN1 : ST_OWN0;
                end else if (req_0) begin
                    state_next = ST_OWN0;
                end else if (req_1) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req_0) begin
                    state_next = req_1 ? ST_OWN1 : ST_IDLE;
                end else if (burst_last && req_1) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req_1) begin
                    state_next = req_0 ? ST_OWN0 : ST_IDLE;
                end else if (burst_last && req_0) begin
                    state_next = ST_OWN0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pointer flips whenever a new owner takes the bus.
    always_comb begin
        ptr_next = ptr;
        if ((state_next != state) && (state_next != ST_IDLE)) begin
            ptr_next = ~ptr;
        end
    end

    // Burst restarts on a state change or when the limit passes uncontested.
    assign burst_clr = (state_next != state) || (gnt_any && burst_last);

    dm_arb_counter #(.WIDTH(BURST_W)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (burst_clr),
        .inc   (gnt_any),
        .count (burst_cnt)
    );

    // Memory port steering; everything parks at zero without a grant.
    always_comb begin
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        write_address = '0;
        read_address  = '0;
        Write_data    = '0;
        if (gnt_0) begin
            if (we_0) begin
                MemWrite      = 1'b1;
                write_address = addr_0;
                Write_data    = wdata_0;
            end else begin
                MemRead      = 1'b1;
                read_address = addr_0;
            end
        end else if (gnt_1) begin
            if (we_1) begin
                MemWrite      = 1'b1;
                write_address = addr_1;
                Write_data    = wdata_1;
            end else begin
                MemRead      = 1'b1;
                read_address = addr_1;
            end
        end
    end

    // Read capture: data held until the owner's next completed read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            rvalid_0 <= gnt_0 && !we_0;
            rvalid_1 <= gnt_1 && !we_1;
            if (gnt_0 && !we_0) begin
                rdata_0 <= MemData_out;
            end
            if (gnt_1 && !we_1) begin
                rdata_1 <= MemData_out;
            end
        end
    end

`ifdef DM_ARBITER_STATS_EN
    logic stall_any;
    assign stall_any = (req_0 && !gnt_0) || (req_1 && !gnt_1);

    dm_arb_counter #(.WIDTH(STAT_W)) u_grant_cnt_0 (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (gnt_0),
        .count (grant_cnt_0)
    );

    dm_arb_counter #(.WIDTH(STAT_W)) u_grant_cnt_1 (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (gnt_1),
        .count (grant_cnt_1)
    );

    dm_arb_counter #(.WIDTH(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (stall_any),
        .count (stall_cnt)
    );
`endif

endmodule
